// File: rtl/gearbox_tx_pkg.sv
// Shared PCS constants for the 66b/64b transmit gearbox.
package gearbox_tx_pkg;
  localparam int PCS_HEAD_W = 2;
  localparam int PCS_DATA_W = 64;
  localparam int BLOCK_W    = PCS_HEAD_W + PCS_DATA_W;
  localparam int GB_SEQ_N   = 33;
  localparam int GB_SEQ_W   = 6;
  // Sequence value at which the residual holds a full word and input stalls.
  localparam logic [GB_SEQ_W-1:0] GB_SEQ_LAST = GB_SEQ_W'(GB_SEQ_N - 1);
endpackage

// File: rtl/gearbox_tx_shift.sv
// Barrel merge: places the new block above the 2*seq valid residual bits
// and splits the result into the outgoing word and the new residual.
module gearbox_tx_shift
  import gearbox_tx_pkg::*;
#(
  parameter int HEAD_W = PCS_HEAD_W,
  parameter int DATA_W = PCS_DATA_W
) (
  input  logic [HEAD_W+DATA_W-1:0] blk,
  input  logic [DATA_W-1:0]        res,
  input  logic [GB_SEQ_W-1:0]      seq,
  output logic [DATA_W-1:0]        res_next,
  output logic [DATA_W-1:0]        word_next
);
  localparam int BW    = HEAD_W + DATA_W;
  localparam int CAT_W = 2 * DATA_W;

  logic [GB_SEQ_W:0] sh;     // 0..64, one bit wider than seq
  logic [DATA_W-1:0] mask;
  logic [CAT_W-1:0]  cat;

  // Only reached with seq <= 31, so blk << (2*seq) always fits in 2*DATA_W bits.
  always_comb begin
    sh   = {seq, 1'b0};
    mask = (sh >= (GB_SEQ_W+1)'(DATA_W)) ? '1 : ((DATA_W'(1) << sh) - DATA_W'(1));
    cat  = ({{(CAT_W-BW){1'b0}}, blk} << sh) | {{DATA_W{1'b0}}, res & mask};
    word_next = cat[DATA_W-1:0];
    res_next  = cat[CAT_W-1:DATA_W];
  end
endmodule

// File: rtl/gearbox_tx.sv
// 66b->64b transmit gearbox: one block in per cycle, one word out per cycle,
// stalling the upstream once every 33 cycles to flush the full residual.
module gearbox_tx
  import gearbox_tx_pkg::*;
#(
  parameter int HEAD_W = PCS_HEAD_W,
  parameter int DATA_W = PCS_DATA_W
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic [HEAD_W-1:0] head_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              accept_o,
  output logic              data_v_o,
  output logic [DATA_W-1:0] data_o
);
  logic [GB_SEQ_W-1:0] seq_q;
  logic [DATA_W-1:0]   res_q;
  logic [DATA_W-1:0]   res_next;
  logic [DATA_W-1:0]   word_next;

  gearbox_tx_shift #(.HEAD_W(HEAD_W), .DATA_W(DATA_W)) u_shift (
    .blk       ({data_i, head_i}),
    .res       (res_q),
    .seq       (seq_q),
    .res_next  (res_next),
    .word_next (word_next)
  );

  // Registered-state only: no combinational path from valid_i.
  assign accept_o = (seq_q != GB_SEQ_LAST);

  // Sequence counter, residual and output word: flush, transfer or idle.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      seq_q    <= '0;
      res_q    <= '0;
      data_o   <= '0;
      data_v_o <= 1'b0;
    end else if (!accept_o) begin
      data_o   <= res_q;
      data_v_o <= 1'b1;
      seq_q    <= '0;
      res_q    <= '0;
    end else if (valid_i) begin
      data_o   <= word_next;
      res_q    <= res_next;
      seq_q    <= seq_q + GB_SEQ_W'(1);
      data_v_o <= 1'b1;
    end else begin
      data_v_o <= 1'b0;
    end
  end

  a_seq_range: assert property (@(posedge clk) disable iff (!nreset)
    seq_q <= GB_SEQ_LAST);
  a_accept: assert property (@(posedge clk)
    accept_o == (seq_q != GB_SEQ_LAST));
  a_vfall: assert property (@(posedge clk) disable iff (!nreset)
    $fell(data_v_o) |-> (!$past(nreset) || $past(accept_o && !valid_i)));
endmodule

// File: tb/tb_gearbox_tx.sv
// Scoreboard bench: the driver pushes accepted block bits into a serial
// bitstream queue; the monitor pops 64 bits per presented word.
module tb_gearbox_tx;
  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        valid_i = 1'b0;
  logic [1:0]  head_i = '0;
  logic [63:0] data_i = '0;
  logic        accept_o, data_v_o;
  logic [63:0] data_o;

  int total = 0;
  int bad   = 0;
  bit bitq[$];   // wire-order bits accepted but not yet emitted
  int vq[$];     // per cycle: 0 idle, 1 word expected, 2 reset cycle

  always #5 clk = ~clk;

  gearbox_tx dut (
    .clk(clk), .nreset(nreset), .valid_i(valid_i), .head_i(head_i),
    .data_i(data_i), .accept_o(accept_o), .data_v_o(data_v_o), .data_o(data_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One cycle of stimulus driven at the falling edge.
  task automatic step(input bit rst, input bit v, input logic [1:0] h,
                      input logic [63:0] d, output bit acc);
    @(negedge clk);
    acc = accept_o;
    if (rst) begin
      nreset = 1'b0; valid_i = 1'b0;
      bitq.delete();
      vq.push_back(2);
    end else begin
      nreset = 1'b1; valid_i = v; head_i = h; data_i = d;
      if (acc && v) begin
        for (int i = 0; i < 2; i++)  bitq.push_back(h[i]);
        for (int i = 0; i < 64; i++) bitq.push_back(d[i]);
        vq.push_back(1);
      end else begin
        vq.push_back(acc ? 0 : 1);
      end
    end
  endtask

  // Monitor: compare each presented cycle against the scoreboard.
  int          m_e;
  logic [63:0] m_w;
  initial begin
    forever begin
      @(posedge clk); #1;
      if (vq.size() != 0) begin
        m_e = vq.pop_front();
        if (m_e == 2) begin
          chk("rst_valid", 64'(data_v_o), 64'd0);
          chk("rst_data", data_o, 64'd0);
          chk("rst_seq", 64'(dut.seq_q), 64'd0);
        end else begin
          chk("data_v", 64'(data_v_o), 64'(m_e));
          if (m_e == 1 && data_v_o) begin
            if (bitq.size() < 64) begin
              total++; bad++;
              $display("FAIL underflow: got %0d bits want 64", bitq.size());
            end else begin
              for (int i = 0; i < 64; i++) m_w[i] = bitq.pop_front();
              chk("word", data_o, m_w);
            end
          end
        end
        chk("accept", 64'(accept_o), 64'(bitq.size() != 64));
      end
    end
  end

  bit          acc;
  int          lows[$];
  logic [1:0]  rh;
  logic [63:0] rd;
  int          n;
  initial begin
    repeat (3) step(1'b1, 1'b0, 2'b0, 64'd0, acc);
    step(1'b0, 1'b1, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, acc);
    chk("accept_after_rst", 64'(acc), 64'd1);
    @(posedge clk); #2 chk("first_word", data_o, 64'hFFFF_FFFF_FFFF_FFFE);
    step(1'b0, 1'b1, 2'b01, 64'd0, acc);
    @(posedge clk); #2 chk("second_word", data_o, 64'h7);
    repeat (15) step(1'b0, 1'b1, 2'($urandom), {$urandom, $urandom}, acc);
    // idle gap at seq 17: counter holds, bitstream resumes unbroken
    repeat (5) begin
      step(1'b0, 1'b0, 2'($urandom), {$urandom, $urandom}, acc);
      @(posedge clk); #2 chk("idle_seq", 64'(dut.seq_q), 64'd17);
    end
    repeat (3) step(1'b0, 1'b1, 2'($urandom), {$urandom, $urandom}, acc);
    step(1'b1, 1'b0, 2'b0, 64'd0, acc);  // reset at seq 20
    // steady state from seq 0 with incrementing payloads
    for (int i = 1; i <= 99; i++) begin
      rh = 2'($urandom);
      rd = 64'h0123_4567_0000_0000 + 64'(i);
      step(1'b0, 1'b1, rh, rd, acc);
      if (!acc) lows.push_back(i);
      if (i == 1) begin
        @(posedge clk); #2 chk("unshifted", data_o, {rd[61:0], rh});
      end
    end
    chk("low_count", 64'(lows.size()), 64'd3);
    if (lows.size() == 3) begin
      chk("low0", 64'(lows[0]), 64'd33);
      chk("low1", 64'(lows[1]), 64'd66);
      chk("low2", 64'(lows[2]), 64'd99);
    end
    // random valid gaps and occasional resets
    for (int i = 0; i < 600; i++)
      step($urandom_range(99) == 0, $urandom_range(9) < 8, 2'($urandom),
           {$urandom, $urandom}, acc);
    step(1'b0, 1'b0, 2'b0, 64'd0, acc);
    n = 0;
    while (vq.size() != 0 && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    if (vq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: got %0d pending want 0", vq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gearbox_tx.md
# gearbox_tx

Transmit-side 66b-to-64b gearbox for the 10GBASE-R PCS. Accepts one 66-bit block per cycle (2-bit sync header plus 64-bit scrambled payload) from the scrambler and emits a continuous stream of 64-bit words to the SerDes. It is the mirror of the receive gearbox and block-sync path: it produces the header alignment that the far-end block lock searches for. A 33-state sequence counter back-pressures the upstream one cycle in every 33 so the 66:64 rate mismatch is absorbed without a FIFO.

## Interface
- `HEAD_W`, 2, sync header width
- `DATA_W`, 64, payload width and SerDes word width
- `clk`  in  1  PCS transmit clock
- `nreset`  in  1  synchronous, active-low reset
- `valid_i`  in  1  upstream block valid
- `head_i`  in  HEAD_W  sync header; `head_i[0]` is the first bit on the wire
- `data_i`  in  DATA_W  scrambled payload; bit 0 is transmitted first after the header
- `accept_o`  out  1  gearbox consumes a block this cycle if `valid_i` is high
- `data_v_o`  out  1  `data_o` holds a new SerDes word
- `data_o`  out  DATA_W  SerDes word; bit 0 is transmitted first

## Operation
- Block: `blk = {data_i, head_i}`, 66 bits, LSB first on the wire.
- State:
  - `seq_q`, 6 bits, range 0..32.
  - Residual buffer `res_q`, 64 bits. Valid bits are `res_q[2*seq_q-1:0]`. All other bits are don't-care but cleared by reset.
- `accept_o = (seq_q != 32)`. This is purely a function of registered state, with no combinational path from `valid_i`.
- Transfer when `accept_o & valid_i`, with s = `seq_q`:
  - Form `cat = {blk, res_q[2s-1:0]}`, 66+2s bits.
  - `data_o <= cat[63:0]`.
  - `res_q <= cat[65+2s:64]`, which is 2s+2 bits, zero-extended.
  - `seq_q <= s+1`.
  - `data_v_o <= 1`.
- Flush at `seq_q == 32`:
  - `res_q` holds exactly 64 bits.
  - `data_o <= res_q`, `data_v_o <= 1`, `seq_q <= 0`, `res_q <= 0`.
  - This happens regardless of `valid_i`, because `accept_o` is low.
- Idle when `accept_o & ~valid_i`:
  - `seq_q`, `res_q` and `data_o` hold.
  - `data_v_o <= 0`.
  - No bits are lost or duplicated. The upstream is expected to keep `valid_i` high in normal operation.
- Arithmetic: the shift amount is `2*seq_q`, 0..64, and needs a 7-bit intermediate. The `seq_q` increment never wraps past 32; the flush is the only path back to 0.

## Timing
- Reset values: `seq_q=0`, `res_q=0`, `data_o=0`, `data_v_o=0`. `accept_o=1` from the first cycle after reset release.
- Latency: one cycle from an accepted block to its first bits appearing on `data_o`.
- With `valid_i` held high, `accept_o` is high for 32 cycles, then low for 1 cycle, periodically. This gives 32 blocks in and 33 words out per period, and `data_v_o` stays high continuously.
- Reset asserted mid-sequence: the residual is discarded and `seq_q` returns to 0 on the next edge. The partial block is lost, and far-end block sync is expected to re-lock.
- The flush cycle ignores `valid_i` and `head_i`/`data_i` entirely.
- Invariant: `seq_q <= 32` always.

## Structure
- Shared PCS package: `BLOCK_W = HEAD_W + DATA_W` (66), `GB_SEQ_N = 33`, `GB_SEQ_W = 6`.
- One natural sub-module, `gearbox_tx_shift`: a combinational barrel merge that takes `blk`, `res_q` and `seq_q` and returns `{res_next, word_next}`. The top level holds the counter, the registers and the accept logic.
- Formal block:
  - Assert `seq_q <= 32`.
  - Assert `accept_o == (seq_q != 32)`.
  - Assert that `data_v_o` falls only after an idle cycle.

## Test plan
- **Reset:** hold `nreset=0` for 3 cycles, then release → `data_v_o=0` and `data_o=0` during reset; `accept_o=1` on the first cycle after release.
- **First words:**
  - Block 1 is `head_i=2'b10`, `data_i=64'hFFFF_FFFF_FFFF_FFFF` → `data_o=64'hFFFF_FFFF_FFFF_FFFE`, with residual `2'b11`.
  - Block 2 is `head_i=2'b01`, `data_i=0` → `data_o=64'h0000_0000_0000_0007`.
- **Steady state:** hold `valid_i=1` with incrementing payloads for 99 cycles → `accept_o` low exactly on cycles 33, 66 and 99; `data_v_o` stays high; a reference serializer bitstream matches bit-exactly.
- **Idle gap:** drop `valid_i` for 5 cycles at `seq_q=17` → `seq_q` holds, `data_v_o=0` for those 5 cycles, and the bitstream is unbroken after resume.
- **Mid-sequence reset:** assert reset at `seq_q=20` → next-cycle `seq_q=0`, `res_q=0`, `data_v_o=0`; the next accepted block appears unshifted on `data_o`.
- **Loopback:** feed `data_o` into the RX gearbox and block sync → `lock_v_o` asserts after 64 valid headers, with no `slip_v_o` after lock.
